// File: rtl/bcd_updn_cnt.sv
// One-digit BCD up/down counter with load, cascade carry and terminal count,
// built as a gate-level netlist of the team cell library (cells follow the top).
module bcd_updn_cnt (
  input  logic       CK,
  input  logic       RN,
  input  logic       EN,
  input  logic       UP,
  input  logic       LD,
  input  logic [3:0] D,
  input  logic       CI,
  output logic [3:0] Q,
  output logic       TC
);

  logic q0_n_s, q3_n_s, up_n_s, en_n_s, ci_n_s;
  logic cnt_s, cnt_n_s, hold_s, ill_s, cup_s, cdn_s, cok_s;
  logic t1u_s, p10_s, t1d_s, p2_s, t2u_s, s2_s, a3n_s, all3_s;
  logic o21_s, is0_s, is9_s, ta_s, tb_s, tt_s, tcn_s, b0_s;
  logic [3:1] up_s, dn_s, bu_s, bd_s;
  logic [3:0] lt_s, x_s, nxt_s;

  inv u_q0n (.A(Q[0]), .Y(q0_n_s));
  inv u_q3n (.A(Q[3]), .Y(q3_n_s));
  inv u_upn (.A(UP),   .Y(up_n_s));
  inv u_enn (.A(EN),   .Y(en_n_s));
  inv u_cin (.A(CI),   .Y(ci_n_s));

  // Mode decode: load wins, then qualified count, else hold.
  nr3  u_cnt  (.A(en_n_s), .B(ci_n_s), .C(LD), .Y(cnt_s));
  inv  u_cntn (.A(cnt_s), .Y(cnt_n_s));
  nr2  u_hold (.A(LD), .B(cnt_s), .Y(hold_s));
  oa21 u_ill  (.A1(Q[2]), .A2(Q[1]), .B(Q[3]), .Y(ill_s));
  nr3  u_cup  (.A(cnt_n_s), .B(ill_s), .C(up_n_s), .Y(cup_s));
  nr3  u_cdn  (.A(cnt_n_s), .B(ill_s), .C(UP), .Y(cdn_s));
  nr2  u_cok  (.A(cnt_n_s), .B(ill_s), .Y(cok_s));

  // Per-direction successors, valid only for legal digits 0..9.
  nr3  u_t1u (.A(q0_n_s), .B(Q[1]), .C(Q[3]), .Y(t1u_s));
  ao21 u_up1 (.A1(Q[1]), .A2(q0_n_s), .B(t1u_s), .Y(up_s[1]));
  nr2  u_p10 (.A(Q[1]), .B(Q[0]), .Y(p10_s));
  oa21 u_t1d (.A1(Q[2]), .A2(Q[3]), .B(p10_s), .Y(t1d_s));
  ao21 u_dn1 (.A1(Q[1]), .A2(Q[0]), .B(t1d_s), .Y(dn_s[1]));
  nd2  u_p2  (.A(Q[1]), .B(Q[0]), .Y(p2_s));
  nr2  u_t2u (.A(Q[2]), .B(p2_s), .Y(t2u_s));
  ao21 u_up2 (.A1(Q[2]), .A2(p2_s), .B(t2u_s), .Y(up_s[2]));
  oa21 u_s2  (.A1(Q[1]), .A2(Q[0]), .B(Q[2]), .Y(s2_s));
  ao21 u_dn2 (.A1(Q[3]), .A2(q0_n_s), .B(s2_s), .Y(dn_s[2]));
  nd3  u_a3n (.A(Q[2]), .B(Q[1]), .C(Q[0]), .Y(a3n_s));
  inv  u_all (.A(a3n_s), .Y(all3_s));
  ao21 u_up3 (.A1(Q[3]), .A2(q0_n_s), .B(all3_s), .Y(up_s[3]));
  or2  u_o21 (.A(Q[2]), .B(Q[1]), .Y(o21_s));
  nr3  u_is0 (.A(o21_s), .B(Q[0]), .C(Q[3]), .Y(is0_s));
  ao21 u_dn3 (.A1(Q[3]), .A2(Q[0]), .B(is0_s), .Y(dn_s[3]));

  // Bit 0 toggles in both directions, so one count term suffices.
  nd2 u_lt0 (.A(LD), .B(D[0]), .Y(lt_s[0]));
  nd2 u_b0  (.A(cok_s), .B(q0_n_s), .Y(b0_s));
  nd2 u_x0  (.A(lt_s[0]), .B(b0_s), .Y(x_s[0]));

  genvar i;
  generate
    for (i = 1; i < 4; i++) begin : g_sel
      nd2 u_lt (.A(LD), .B(D[i]), .Y(lt_s[i]));
      nd2 u_bu (.A(cup_s), .B(up_s[i]), .Y(bu_s[i]));
      nd2 u_bd (.A(cdn_s), .B(dn_s[i]), .Y(bd_s[i]));
      nd3 u_x  (.A(lt_s[i]), .B(bu_s[i]), .C(bd_s[i]), .Y(x_s[i]));
    end
    for (i = 0; i < 4; i++) begin : g_bit
      ao21 u_nxt (.A1(hold_s), .A2(Q[i]), .B(x_s[i]), .Y(nxt_s[i]));
      dffr u_ff  (.D(nxt_s[i]), .CK(CK), .RN(RN), .Q(Q[i]));
    end
  endgenerate

  // Terminal count uses exact 9/0 decodes on Q, never the next-state cone.
  nr3 u_is9 (.A(q3_n_s), .B(o21_s), .C(q0_n_s), .Y(is9_s));
  nd2 u_ta  (.A(UP), .B(is9_s), .Y(ta_s));
  nd2 u_tb  (.A(up_n_s), .B(is0_s), .Y(tb_s));
  nd2 u_tt  (.A(ta_s), .B(tb_s), .Y(tt_s));
  nd2 u_tcn (.A(cnt_s), .B(tt_s), .Y(tcn_s));
  inv u_tc  (.A(tcn_s), .Y(TC));

endmodule

// Cell library. ao/oa cells are non-inverting: ao21 = A1&A2 | B, oa21 = (A1|A2) & B.
module inv (input logic A, output logic Y);
  assign Y = ~A;
endmodule

module nd2 (input logic A, input logic B, output logic Y);
  assign Y = ~(A & B);
endmodule

module nd3 (input logic A, input logic B, input logic C, output logic Y);
  assign Y = ~(A & B & C);
endmodule

module nr2 (input logic A, input logic B, output logic Y);
  assign Y = ~(A | B);
endmodule

module nr3 (input logic A, input logic B, input logic C, output logic Y);
  assign Y = ~(A | B | C);
endmodule

module or2 (input logic A, input logic B, output logic Y);
  assign Y = A | B;
endmodule

module ao21 (input logic A1, input logic A2, input logic B, output logic Y);
  assign Y = (A1 & A2) | B;
endmodule

module oa21 (input logic A1, input logic A2, input logic B, output logic Y);
  assign Y = (A1 | A2) & B;
endmodule

module dffr (
  input  logic D,
  input  logic CK,
  input  logic RN,
  output logic Q
);
  // Storage bit with asynchronous active-low clear
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) Q <= 1'b0;
    else     Q <= D;
  end
endmodule

// File: tb/tb_bcd_updn_cnt.sv
// Directed bench for bcd_updn_cnt: vector table plus reset and two-digit cascade sequences.
`timescale 1ns/1ps
module tb_bcd_updn_cnt;

  typedef struct packed {
    logic       ld;
    logic       en;
    logic       ci;
    logic       up;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  logic       ck = 1'b0;
  logic       rn, en, ci, up, ld;
  logic [3:0] d, q, lo_q, hi_q;
  logic       tc, lo_tc, hi_tc;
  int         n_vec = 0;
  int         n_miss = 0;
  vec_t       tbl[$];

  always #5 ck = ~ck;

  bcd_updn_cnt dut (.CK(ck), .RN(rn), .EN(en), .UP(up), .LD(ld), .D(d), .CI(ci),
                    .Q(q), .TC(tc));
  bcd_updn_cnt u_lo (.CK(ck), .RN(rn), .EN(1'b1), .UP(1'b1), .LD(1'b0), .D(4'd0),
                     .CI(1'b1), .Q(lo_q), .TC(lo_tc));
  bcd_updn_cnt u_hi (.CK(ck), .RN(rn), .EN(1'b1), .UP(1'b1), .LD(1'b0), .D(4'd0),
                     .CI(lo_tc), .Q(hi_q), .TC(hi_tc));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic l, input logic e, input logic c, input logic u,
                             input logic [3:0] dd, input logic [3:0] qq, input logic t);
    return '{l, e, c, u, dd, qq, t};
  endfunction

  initial begin
    // up count 0 -> 1..9,0,1,2 ; TC only while Q=9
    for (int k = 1; k <= 12; k++)
      tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'(k % 10), (k == 10)));
    // load 2, count down with wrap ; TC only while Q=0
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0));
    // illegal loads and one-edge recovery
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 4'd13, 4'd13, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0));
    tbl.push_back(v(1'b1, 1'b0, 1'b1, 1'b1, 4'd10, 4'd10, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd10, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd10, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0));
    // priority and hold
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0));
    // TC gating at Q=9
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 1'b0));
    tbl.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b0));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0));
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0));
    // mid-range up/down, more illegal loads
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd6, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0));
    tbl.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 4'd12, 1'b0));
    tbl.push_back(v(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0));

    // reset state, including the down-terminal TC while held in reset
    rn = 1'b0; en = 1'b0; ci = 1'b0; up = 1'b0; ld = 1'b0; d = 4'd0;
    @(posedge ck); #1;
    chk("rst_q", 8'(q), 8'd0);
    chk("rst_tc", 8'(tc), 8'd0);
    en = 1'b1; ci = 1'b1; #1;
    chk("rst_tc_dn", 8'(tc), 8'd1);
    up = 1'b1; #1;
    chk("rst_tc_up", 8'(tc), 8'd0);
    en = 1'b0;
    @(negedge ck); rn = 1'b1; #1;
    chk("rel_q", 8'(q), 8'd0);
    @(posedge ck); #1;

    foreach (tbl[i]) begin
      ld = tbl[i].ld; en = tbl[i].en; ci = tbl[i].ci; up = tbl[i].up; d = tbl[i].d;
      #1;
      chk($sformatf("tc[%0d]", i), 8'(tc), 8'(tbl[i].tc));
      @(posedge ck); #1;
      chk($sformatf("q[%0d]", i), 8'(q), 8'(tbl[i].q));
    end

    // asynchronous reset between edges while counting
    ld = 1'b1; d = 4'd4; en = 1'b1; ci = 1'b1; up = 1'b1;
    @(posedge ck); #1;
    ld = 1'b0;
    @(posedge ck); #1;
    chk("mid_q5", 8'(q), 8'd5);
    @(negedge ck); rn = 1'b0; #1;
    chk("arst_q", 8'(q), 8'd0);
    chk("arst_tc_up", 8'(tc), 8'd0);
    up = 1'b0; #1;
    chk("arst_tc_dn", 8'(tc), 8'd1);
    up = 1'b1;
    @(posedge ck); #1;
    chk("arst_hold", 8'(q), 8'd0);
    @(negedge ck); rn = 1'b1; #1;
    chk("arst_rel", 8'(q), 8'd0);
    @(posedge ck); #1;
    chk("arst_first", 8'(q), 8'd1);

    // reset coincident with a loading edge
    ld = 1'b1; d = 4'd7;
    @(posedge ck); rn = 1'b0; #1;
    chk("coinc_q", 8'(q), 8'd0);
    @(negedge ck); rn = 1'b1; ld = 1'b0; en = 1'b0;
    @(posedge ck); #1;
    chk("coinc_hold", 8'(q), 8'd0);

    // two-digit cascade 00..99 then 00
    @(negedge ck); rn = 1'b0; #1;
    chk("casc_rst", {hi_q, lo_q}, 8'h00);
    @(negedge ck); rn = 1'b1; #1;
    for (int k = 1; k <= 100; k++) begin
      chk($sformatf("casc_tc[%0d]", k - 1), 8'(hi_tc), 8'(k == 100));
      @(posedge ck); #1;
      chk($sformatf("casc[%0d]", k), {hi_q, lo_q},
          {4'((k % 100) / 10), 4'(k % 10)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
